// File: rtl/knn_sort_ctrl.sv
// Frame sequencer for the KNN distance sorter: loads and pads a frame, runs the sorter
// under a timeout, then takes a majority vote over the K nearest classes.
module knn_sort_ctrl #(
    parameter int N       = 64,
    parameter int B       = 32,
    parameter int K       = 5,
    parameter int NCLASS  = 8,
    parameter int TIMEOUT = 4096
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [B-1:0]             in_distance,
    input  logic [B-1:0]             in_type,
    input  logic                     in_last,
    output logic                     sort_start,
    output logic [N*B-1:0]           sort_dist,
    output logic [N*B-1:0]           sort_type,
    input  logic                     sort_done,
    input  logic [N*B-1:0]           sorted_type,
    output logic                     class_valid,
    input  logic                     class_ready,
    output logic [B-1:0]             class_out,
    output logic [$clog2(K+1)-1:0]   class_votes,
    output logic                     busy,
    output logic                     timeout
);
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam int VW    = $clog2(K + 1);
    localparam int TW    = $clog2(TIMEOUT + 1);
    localparam int CW    = (NCLASS > 1) ? $clog2(NCLASS) : 1;

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SORT, S_VOTE, S_OUT} state_t;

    state_t            state, state_next;
    logic [IDX_W-1:0]  idx;
    logic [IDX_W-1:0]  vote_idx;
    logic [TW-1:0]     tmr;
    logic              seen_low;
    logic [VW-1:0]     cnt [2**CW];
    logic [B-1:0]      best_class;
    logic [VW-1:0]     best_cnt;

    logic              accept, close, done_q, tmr_expired, vote_last;
    logic [B-1:0]      vote_type;
    logic [CW-1:0]     vote_cls;
    logic [VW-1:0]     cnt_next;
    logic              vote_ok;

    // NOTE: in_ready is gated by rst so every output reads 0 while reset is held.
    assign in_ready    = ~rst & (state == S_IDLE || state == S_LOAD);
    assign accept      = in_valid & in_ready;
    assign close       = accept & (in_last | (idx == IDX_W'(N - 1)));
    // A done level left over from a previous sort must drop before it is trusted.
    assign done_q      = sort_done & seen_low;
    assign tmr_expired = (tmr == TW'(TIMEOUT - 1));
    assign vote_last   = (vote_idx == IDX_W'(K - 1));

    assign vote_type   = sorted_type[int'(vote_idx)*B +: B];
    assign vote_cls    = vote_type[CW-1:0];
    assign vote_ok     = (vote_type < B'(NCLASS));
    assign cnt_next    = cnt[vote_cls] + VW'(1);

    assign class_out   = best_class;
    assign class_votes = best_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_next;
    end

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        state_next  = state;
        sort_start  = 1'b0;
        class_valid = 1'b0;
        busy        = (state != S_IDLE);
        case (state)
            S_IDLE: if (accept) state_next = close ? S_SORT : S_LOAD;
            S_LOAD: if (close)  state_next = S_SORT;
            S_SORT: begin
                sort_start = 1'b1;
                if (done_q)           state_next = S_VOTE;
                else if (tmr_expired) state_next = S_IDLE;
            end
            S_VOTE: if (vote_last) state_next = S_OUT;
            S_OUT: begin
                class_valid = 1'b1;
                if (class_ready) state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // NOTE: the banks are reset to zero because they drive sort_dist/sort_type directly.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx        <= '0;
            sort_dist  <= '0;
            sort_type  <= '0;
            tmr        <= '0;
            seen_low   <= 1'b0;
            vote_idx   <= '0;
            best_class <= '0;
            best_cnt   <= '0;
            timeout    <= 1'b0;
            for (int c = 0; c < 2**CW; c++) cnt[c] <= '0;
        end else begin
            timeout <= (state == S_SORT) && !done_q && tmr_expired;

            if (accept) begin
                idx <= close ? '0 : idx + IDX_W'(1);
                for (int i = 0; i < N; i++) begin
                    if (IDX_W'(i) == idx) begin
                        sort_dist[i*B +: B] <= in_distance;
                        sort_type[i*B +: B] <= in_type;
                    end else if (close && IDX_W'(i) > idx) begin
                        sort_dist[i*B +: B] <= {B{1'b1}};
                        sort_type[i*B +: B] <= B'(NCLASS);
                    end
                end
            end

            if (state == S_SORT) begin
                tmr <= tmr + TW'(1);
                if (!sort_done) seen_low <= 1'b1;
            end else begin
                tmr      <= '0;
                seen_low <= 1'b0;
            end

            if (state == S_SORT && done_q) begin
                vote_idx   <= '0;
                best_class <= B'(NCLASS);
                best_cnt   <= '0;
                for (int c = 0; c < 2**CW; c++) cnt[c] <= '0;
            end else if (state == S_VOTE) begin
                vote_idx <= vote_idx + IDX_W'(1);
                if (vote_ok) begin
                    cnt[vote_cls] <= cnt_next;
                    // Strict compare keeps the class that reached this count first.
                    if (cnt_next > best_cnt) begin
                        best_class <= vote_type;
                        best_cnt   <= cnt_next;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_knn_sort_ctrl.sv
// Directed bench for knn_sort_ctrl with a behavioural 10-cycle sorter model.
module tb_knn_sort_ctrl;
    localparam int N = 8, B = 32, K = 3, NCLASS = 6, TIMEOUT = 64;
    localparam int VW = $clog2(K + 1);

    typedef logic [31:0] word_arr_t [N];

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           in_valid = 1'b0, in_last = 1'b0, class_ready = 1'b0;
    logic [B-1:0]   in_distance = '0, in_type = '0;
    logic           in_ready, sort_start, sort_done, class_valid, busy, timeout;
    logic [N*B-1:0] sort_dist, sort_type, sorted_type;
    logic [B-1:0]   class_out;
    logic [VW-1:0]  class_votes;

    int n_checks = 0;
    int n_fail   = 0;

    logic [3:0] lat_cnt;
    logic       model_done;
    logic       stuck_en = 1'b0, stuck_val = 1'b0;

    knn_sort_ctrl #(.N(N), .B(B), .K(K), .NCLASS(NCLASS), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_distance(in_distance), .in_type(in_type), .in_last(in_last),
        .sort_start(sort_start), .sort_dist(sort_dist), .sort_type(sort_type),
        .sort_done(sort_done), .sorted_type(sorted_type), .class_valid(class_valid),
        .class_ready(class_ready), .class_out(class_out), .class_votes(class_votes),
        .busy(busy), .timeout(timeout)
    );

    always #5 clk = ~clk;

    // Sorter model: done rises 10 cycles into sort_start, falls when it drops.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            lat_cnt <= '0; model_done <= 1'b0;
        end else if (!sort_start) begin
            lat_cnt <= '0; model_done <= 1'b0;
        end else if (lat_cnt == 4'd9) begin
            model_done <= 1'b1;
        end else begin
            lat_cnt <= lat_cnt + 4'd1;
        end
    end
    assign sort_done = stuck_en ? stuck_val : model_done;

    function automatic logic [N*B-1:0] sort_types(input logic [N*B-1:0] d, input logic [N*B-1:0] t);
        logic [31:0] dv [N];
        logic [31:0] tv [N];
        logic [31:0] kd, kt;
        logic [N*B-1:0] r;
        int j;
        for (int i = 0; i < N; i++) begin dv[i] = d[i*B +: B]; tv[i] = t[i*B +: B]; end
        for (int i = 1; i < N; i++) begin
            kd = dv[i]; kt = tv[i]; j = i - 1;
            while (j >= 0 && dv[j] > kd) begin dv[j+1] = dv[j]; tv[j+1] = tv[j]; j--; end
            dv[j+1] = kd; tv[j+1] = kt;
        end
        for (int i = 0; i < N; i++) r[i*B +: B] = tv[i];
        return r;
    endfunction

    always_comb sorted_type = sort_types(sort_dist, sort_type);

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    // Called at a negedge; returns at the negedge after the last accept.
    task automatic send_frame(input word_arr_t d, input word_arr_t t, input int len, input bit use_last);
        for (int i = 0; i < len; i++) begin
            in_valid = 1'b1; in_distance = d[i]; in_type = t[i];
            in_last = use_last && (i == len - 1);
            n_checks++;
            if (in_ready !== 1'b1) begin
                n_fail++; $display("FAIL load_ready[%0d]: in_ready=%b expected 1", i, in_ready);
            end
            @(posedge clk); @(negedge clk);
        end
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    task automatic wait_done(output bit found);
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            if (sort_done && sort_start) found = 1'b1;
            else @(negedge clk);
        end
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (!class_valid && lat < 50) begin @(negedge clk); lat++; end
    endtask

    task automatic ack();
        class_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        class_ready = 1'b0;
    endtask

    task automatic run_and_check(input string name, input logic [31:0] exp_class, input int exp_votes);
        bit found; int lat;
        wait_done(found);
        n_checks++;
        if (!found) begin n_fail++; $display("FAIL %s_done: sort_done never seen", name); end
        wait_valid(lat);
        n_checks++;
        if (lat !== K + 1) begin n_fail++; $display("FAIL %s_latency: got %0d cycles expected %0d", name, lat, K + 1); end
        n_checks++;
        if (class_out !== exp_class) begin n_fail++; $display("FAIL %s_class: got %0d expected %0d", name, class_out, exp_class); end
        n_checks++;
        if (int'(class_votes) !== exp_votes) begin n_fail++; $display("FAIL %s_votes: got %0d expected %0d", name, class_votes, exp_votes); end
    endtask

    task automatic test_reset();
        @(negedge clk); @(negedge clk);
        n_checks++;
        if ({in_ready, sort_start, class_valid, busy, timeout} !== 5'b0) begin
            n_fail++; $display("FAIL reset_outputs: got %b expected 00000", {in_ready, sort_start, class_valid, busy, timeout});
        end
        n_checks++;
        if (sort_dist !== '0 || sort_type !== '0 || class_out !== '0 || class_votes !== '0) begin
            n_fail++; $display("FAIL reset_banks: dist0=%h type0=%h class=%0d expected all 0", sort_dist[31:0], sort_type[31:0], class_out);
        end
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (in_ready !== 1'b1 || busy !== 1'b0) begin
            n_fail++; $display("FAIL reset_idle: in_ready=%b busy=%b expected 1/0", in_ready, busy);
        end
    endtask

    task automatic test_full_tie();
        word_arr_t d = '{7, 6, 5, 4, 3, 2, 1, 0};
        word_arr_t t = '{0, 1, 2, 3, 2, 2, 4, 5};
        send_frame(d, t, N, 1'b1);
        run_and_check("tie", 32'd5, 1);
        ack();
    endtask

    task automatic test_full_majority();
        word_arr_t d = '{0, 1, 2, 3, 4, 5, 6, 7};
        word_arr_t t = '{2, 1, 2, 0, 0, 0, 0, 0};
        send_frame(d, t, N, 1'b0);
        n_checks++;
        if (sort_start !== 1'b1 || in_ready !== 1'b0) begin
            n_fail++; $display("FAIL full_close: sort_start=%b in_ready=%b expected 1/0", sort_start, in_ready);
        end
        run_and_check("majority", 32'd2, 2);
        ack();
    endtask

    task automatic test_short_frame();
        word_arr_t d = '{10, 20, 30, 0, 0, 0, 0, 0};
        word_arr_t t = '{1, 1, 3, 0, 0, 0, 0, 0};
        bit bank_ok = 1'b1;
        send_frame(d, t, 3, 1'b1);
        n_checks++;
        if (sort_start !== 1'b1) begin n_fail++; $display("FAIL short_start: sort_start=%b expected 1", sort_start); end
        for (int i = 0; i < N; i++) begin
            if (i < 3 && (sort_dist[i*B +: B] !== d[i] || sort_type[i*B +: B] !== t[i])) bank_ok = 1'b0;
            if (i >= 3 && (sort_dist[i*B +: B] !== 32'hFFFF_FFFF || sort_type[i*B +: B] !== 32'd6)) bank_ok = 1'b0;
        end
        n_checks++;
        if (!bank_ok) begin n_fail++; $display("FAIL short_pad: dist3=%h type3=%0d expected ffffffff/6", sort_dist[3*B +: B], sort_type[3*B +: B]); end
        in_valid = 1'b1; in_distance = 32'd99; in_type = 32'd4;
        n_checks++;
        if (in_ready !== 1'b0) begin n_fail++; $display("FAIL sort_ready: in_ready=%b expected 0", in_ready); end
        @(posedge clk); @(negedge clk);
        in_valid = 1'b0;
        n_checks++;
        if (sort_dist[B-1:0] !== 32'd10 || sort_type[B-1:0] !== 32'd1) begin
            n_fail++; $display("FAIL sort_frozen: dist0=%0d type0=%0d expected 10/1", sort_dist[B-1:0], sort_type[B-1:0]);
        end
        run_and_check("short", 32'd1, 2);
        ack();
    endtask

    task automatic test_padded_vote();
        word_arr_t d = '{1, 2, 0, 0, 0, 0, 0, 0};
        word_arr_t t = '{7, 6, 0, 0, 0, 0, 0, 0};
        send_frame(d, t, 2, 1'b1);
        run_and_check("padded", 32'd6, 0);
        ack();
    endtask

    task automatic test_stale_done();
        word_arr_t d = '{7, 6, 5, 4, 3, 2, 1, 0};
        word_arr_t t = '{0, 1, 2, 3, 2, 2, 4, 5};
        int lat;
        stuck_en = 1'b1; stuck_val = 1'b1;
        send_frame(d, t, N, 1'b1);
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if (sort_start !== 1'b1 || busy !== 1'b1) begin
                n_fail++; $display("FAIL stale_hold[%0d]: sort_start=%b busy=%b expected 1/1", i, sort_start, busy);
            end
            @(negedge clk);
        end
        stuck_val = 1'b0;
        @(negedge clk);
        stuck_val = 1'b1;
        wait_valid(lat);
        n_checks++;
        if (lat !== K + 1) begin n_fail++; $display("FAIL stale_latency: got %0d cycles expected %0d", lat, K + 1); end
        n_checks++;
        if (class_out !== 32'd5 || class_votes !== 2'd1) begin
            n_fail++; $display("FAIL stale_result: class=%0d votes=%0d expected 5/1", class_out, class_votes);
        end
        ack();
        stuck_en = 1'b0;
    endtask

    task automatic test_timeout();
        word_arr_t d = '{0, 1, 2, 3, 4, 5, 6, 7};
        word_arr_t t = '{2, 1, 2, 0, 0, 0, 0, 0};
        int seen_at = -1;
        stuck_en = 1'b1; stuck_val = 1'b1;
        send_frame(d, t, N, 1'b1);
        for (int i = 0; i <= TIMEOUT + 4 && seen_at < 0; i++) begin
            if (timeout) seen_at = i;
            else @(negedge clk);
        end
        n_checks++;
        if (seen_at !== TIMEOUT) begin n_fail++; $display("FAIL timeout_cycle: got %0d expected %0d", seen_at, TIMEOUT); end
        n_checks++;
        if (busy !== 1'b0 || in_ready !== 1'b1 || sort_start !== 1'b0 || class_valid !== 1'b0) begin
            n_fail++; $display("FAIL timeout_state: busy=%b in_ready=%b sort_start=%b class_valid=%b expected 0/1/0/0",
                               busy, in_ready, sort_start, class_valid);
        end
        @(negedge clk);
        n_checks++;
        if (timeout !== 1'b0 || class_valid !== 1'b0) begin
            n_fail++; $display("FAIL timeout_pulse: timeout=%b class_valid=%b expected 0/0", timeout, class_valid);
        end
        stuck_en = 1'b0; stuck_val = 1'b0;
    endtask

    task automatic test_backpressure_and_reset();
        word_arr_t d = '{0, 1, 2, 3, 4, 5, 6, 7};
        word_arr_t t = '{2, 1, 2, 0, 0, 0, 0, 0};
        send_frame(d, t, N, 1'b1);
        run_and_check("hold", 32'd2, 2);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_checks++;
            if (class_valid !== 1'b1 || class_out !== 32'd2 || class_votes !== 2'd2) begin
                n_fail++; $display("FAIL hold[%0d]: valid=%b class=%0d votes=%0d expected 1/2/2", i, class_valid, class_out, class_votes);
            end
        end
        ack();
        n_checks++;
        if (class_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++; $display("FAIL back_to_back: valid=%b busy=%b in_ready=%b expected 0/0/1", class_valid, busy, in_ready);
        end
        send_frame(d, t, N, 1'b1);
        @(negedge clk); @(negedge clk);
        n_checks++;
        if (sort_start !== 1'b1) begin n_fail++; $display("FAIL pre_reset: sort_start=%b expected 1", sort_start); end
        rst = 1'b1;
        #1;
        n_checks++;
        if (sort_start !== 1'b0 || busy !== 1'b0 || class_valid !== 1'b0 || in_ready !== 1'b0) begin
            n_fail++; $display("FAIL mid_reset: sort_start=%b busy=%b valid=%b in_ready=%b expected 0/0/0/0",
                               sort_start, busy, class_valid, in_ready);
        end
        n_checks++;
        if (sort_dist !== '0 || sort_type !== '0) begin n_fail++; $display("FAIL mid_reset_banks: dist0=%h expected 0", sort_dist[B-1:0]); end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (in_ready !== 1'b1 || busy !== 1'b0) begin
            n_fail++; $display("FAIL post_reset: in_ready=%b busy=%b expected 1/0", in_ready, busy);
        end
    endtask

    initial begin
        test_reset();
        test_full_tie();
        test_full_majority();
        test_short_frame();
        test_padded_vote();
        test_stale_done();
        test_timeout();
        test_backpressure_and_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
